// File: rtl/trap_controller_if.sv
`default_nettype none
// ============================================================================
// Module   : trap_controller_if
// Purpose  : Pipeline/CSR-side bundle for the trap sequencer: exception
//            requests, MRET, CSR vectors in; CSR strobe and redirect out.
// Revision : 1.0 - initial release
// ============================================================================
interface trap_controller_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  exc_valid;
    logic                  exc_fetch_misaligned;
    logic                  exc_illegal;
    logic                  exc_ebreak;
    logic                  exc_ecall;
    logic                  exc_load_misaligned;
    logic                  exc_store_misaligned;
    logic [DATA_WIDTH-1:0] exc_pc;
    logic [DATA_WIDTH-1:0] exc_instr;
    logic                  mret;
    logic [DATA_WIDTH-1:0] csr_mtvec;
    logic [DATA_WIDTH-1:0] csr_mepc;

    logic                  exception;
    logic [7:0]            exception_code;
    logic [DATA_WIDTH-1:0] trap_pc;
    logic [DATA_WIDTH-1:0] trap_instr;
    logic                  flush;
    logic                  stall;
    logic                  redirect_valid;
    logic [DATA_WIDTH-1:0] redirect_pc;

    modport master (
        output exc_valid, exc_fetch_misaligned, exc_illegal, exc_ebreak,
               exc_ecall, exc_load_misaligned, exc_store_misaligned,
               exc_pc, exc_instr, mret, csr_mtvec, csr_mepc,
        input  exception, exception_code, trap_pc, trap_instr,
               flush, stall, redirect_valid, redirect_pc
    );

    modport slave (
        input  exc_valid, exc_fetch_misaligned, exc_illegal, exc_ebreak,
               exc_ecall, exc_load_misaligned, exc_store_misaligned,
               exc_pc, exc_instr, mret, csr_mtvec, csr_mepc,
        output exception, exception_code, trap_pc, trap_instr,
               flush, stall, redirect_valid, redirect_pc
    );
endinterface
`default_nettype wire

// File: rtl/trap_controller.sv
`default_nettype none
// ============================================================================
// Module   : trap_controller
// Purpose  : Machine-mode trap sequencer: prioritises exceptions, strobes the
//            CSR file, then redirects fetch to mtvec (or to mepc on MRET).
//            Define TRAP_MRET_EN for native MRET; otherwise MRET traps as illegal.
// Revision : 1.0 - initial release
// ============================================================================
module trap_controller #(
    parameter int DATA_WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    trap_controller_if.slave bus
);

    localparam logic [7:0] c_code_fetch_misaligned = 8'h00;
    localparam logic [7:0] c_code_illegal          = 8'h02;
    localparam logic [7:0] c_code_ebreak           = 8'h03;
    localparam logic [7:0] c_code_ecall            = 8'h0B;
    localparam logic [7:0] c_code_load_misaligned  = 8'h04;
    localparam logic [7:0] c_code_store_misaligned = 8'h06;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SAVE     = 3'd1,
        ST_WAIT     = 3'd2,
        ST_REDIRECT = 3'd3
`ifdef TRAP_MRET_EN
        ,
        ST_MRET     = 3'd4
`endif
    } state_t;

    state_t                r_state;
    logic                  r_exception;
    logic                  r_flush;
    logic                  r_stall;
    logic                  r_redirect_valid;
    logic [7:0]            r_code;
    logic [DATA_WIDTH-1:0] r_trap_pc;
    logic [DATA_WIDTH-1:0] r_trap_instr;

    logic                  w_any_flag;
    logic                  w_take_trap;
    logic [7:0]            w_flag_code;
    logic [7:0]            w_trap_code;
    logic [DATA_WIDTH-1:0] w_redirect_pc;

    assign w_any_flag = bus.exc_valid &
                        (bus.exc_fetch_misaligned | bus.exc_illegal |
                         bus.exc_ebreak | bus.exc_ecall |
                         bus.exc_load_misaligned | bus.exc_store_misaligned);

    // Fixed priority: ecall deliberately outranks the misaligned data accesses.
    always_comb begin
        w_flag_code = c_code_store_misaligned;
        if (bus.exc_fetch_misaligned)
            w_flag_code = c_code_fetch_misaligned;
        else if (bus.exc_illegal)
            w_flag_code = c_code_illegal;
        else if (bus.exc_ebreak)
            w_flag_code = c_code_ebreak;
        else if (bus.exc_ecall)
            w_flag_code = c_code_ecall;
        else if (bus.exc_load_misaligned)
            w_flag_code = c_code_load_misaligned;
    end

`ifdef TRAP_MRET_EN
    logic w_take_mret;
    assign w_take_trap = w_any_flag;
    assign w_trap_code = w_flag_code;
    assign w_take_mret = bus.mret & ~w_any_flag;
`else
    // Without MRET support the instruction is simply unimplemented.
    logic w_unused_mepc;
    assign w_take_trap   = w_any_flag | bus.mret;
    assign w_trap_code   = w_any_flag ? w_flag_code : c_code_illegal;
    assign w_unused_mepc = ^bus.csr_mepc;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state          <= ST_IDLE;
            r_exception      <= 1'b0;
            r_flush          <= 1'b0;
            r_stall          <= 1'b0;
            r_redirect_valid <= 1'b0;
            r_code           <= '0;
            r_trap_pc        <= '0;
            r_trap_instr     <= '0;
        end else begin
            r_exception      <= 1'b0;
            r_flush          <= 1'b0;
            r_stall          <= 1'b0;
            r_redirect_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_take_trap) begin
                        r_state      <= ST_SAVE;
                        r_code       <= w_trap_code;
                        r_trap_pc    <= bus.exc_pc;
                        r_trap_instr <= bus.exc_instr;
                        r_exception  <= 1'b1;
                        r_flush      <= 1'b1;
                        r_stall      <= 1'b1;
                    end
`ifdef TRAP_MRET_EN
                    else if (w_take_mret) begin
                        r_state          <= ST_MRET;
                        r_redirect_valid <= 1'b1;
                        r_flush          <= 1'b1;
                    end
`endif
                end
                ST_SAVE: begin
                    r_state <= ST_WAIT;
                    r_stall <= 1'b1;
                end
                ST_WAIT: begin
                    r_state          <= ST_REDIRECT;
                    r_redirect_valid <= 1'b1;
                    r_stall          <= 1'b1;
                end
                ST_REDIRECT: begin
                    r_state <= ST_IDLE;
                end
`ifdef TRAP_MRET_EN
                ST_MRET: begin
                    r_state <= ST_IDLE;
                end
`endif
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        w_redirect_pc = '0;
        if (r_state == ST_REDIRECT)
            w_redirect_pc = bus.csr_mtvec;
`ifdef TRAP_MRET_EN
        else if (r_state == ST_MRET)
            w_redirect_pc = bus.csr_mepc;
`endif
    end

    assign bus.exception      = r_exception;
    assign bus.exception_code = r_code;
    assign bus.trap_pc        = r_trap_pc;
    assign bus.trap_instr     = r_trap_instr;
    assign bus.flush          = r_flush;
    assign bus.stall          = r_stall;
    assign bus.redirect_valid = r_redirect_valid;
    assign bus.redirect_pc    = w_redirect_pc;

endmodule
`default_nettype wire

// File: tb/tb_trap_controller.sv
`default_nettype none
// Bench for trap_controller: directed vector table, hand-written corner
// sequences and randomized traffic checked against a cycle-schedule model.
`timescale 1ns/1ps
module tb_trap_controller;
    localparam int DW = 32;
    localparam logic [5:0] F_FETCH = 6'b000001;
    localparam logic [5:0] F_ILL   = 6'b000010;
    localparam logic [5:0] F_EBRK  = 6'b000100;
    localparam logic [5:0] F_ECALL = 6'b001000;
    localparam logic [5:0] F_LOAD  = 6'b010000;
    localparam logic [5:0] F_STORE = 6'b100000;
    localparam logic [7:0] PRIO_CODE [6] = '{8'h00, 8'h02, 8'h03, 8'h0B, 8'h04, 8'h06};

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    trap_controller_if #(.DATA_WIDTH(DW)) bus ();
    trap_controller #(.DATA_WIDTH(DW)) dut (.clk(clk), .reset(reset), .bus(bus));

    int total = 0;
    int bad   = 0;

    // Model: each accepted request schedules the exact output frames for the
    // following cycles; new requests are only considered when nothing is scheduled.
    typedef struct {
        bit          exc;
        bit          flush;
        bit          stall;
        bit          rv;
        int unsigned sel;   // 0: redirect_pc 0, 1: mtvec, 2: mepc
    } frame_t;
    frame_t      sched[$];
    frame_t      cur;
    logic [7:0]  m_code;
    logic [31:0] m_pc;
    logic [31:0] m_instr;

    typedef struct {
        logic        valid;
        logic [5:0]  flags;
        logic        mret;
        logic [31:0] pc;
        logic [31:0] instr;
        logic        exp_exc;
        logic [7:0]  exp_code;
    } vec_t;
    vec_t vecs[$];

    function automatic frame_t mk(bit e, bit f, bit s, bit r, int unsigned sel);
        frame_t t;
        t.exc = e; t.flush = f; t.stall = s; t.rv = r; t.sel = sel;
        return t;
    endfunction

    function automatic vec_t mkv(logic v, logic [5:0] fl, logic m, logic [31:0] pc,
                                 logic [31:0] ins, logic ee, logic [7:0] ec);
        vec_t t;
        t.valid = v; t.flags = fl; t.mret = m; t.pc = pc; t.instr = ins;
        t.exp_exc = ee; t.exp_code = ec;
        return t;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(logic v, logic [5:0] fl, logic m, logic [31:0] pc, logic [31:0] ins);
        bus.exc_valid            = v;
        bus.exc_fetch_misaligned = fl[0];
        bus.exc_illegal          = fl[1];
        bus.exc_ebreak           = fl[2];
        bus.exc_ecall            = fl[3];
        bus.exc_load_misaligned  = fl[4];
        bus.exc_store_misaligned = fl[5];
        bus.mret                 = m;
        bus.exc_pc               = pc;
        bus.exc_instr            = ins;
    endtask

    task automatic model_edge();
        logic [5:0] fl;
        int         code;
        if (!reset) begin
            sched.delete();
            m_code = '0; m_pc = '0; m_instr = '0;
            cur = mk(0, 0, 0, 0, 0);
            return;
        end
        if (sched.size() == 0) begin
            fl = {bus.exc_store_misaligned, bus.exc_load_misaligned, bus.exc_ecall,
                  bus.exc_ebreak, bus.exc_illegal, bus.exc_fetch_misaligned};
            code = -1;
            if (bus.exc_valid)
                for (int i = 0; i < 6; i++)
                    if (fl[i] && code < 0) code = int'(PRIO_CODE[i]);
`ifndef TRAP_MRET_EN
            if (code < 0 && bus.mret) code = 2;
`endif
            if (code >= 0) begin
                m_code  = 8'(code);
                m_pc    = bus.exc_pc;
                m_instr = bus.exc_instr;
                sched.push_back(mk(1, 1, 1, 0, 0));
                sched.push_back(mk(0, 0, 1, 0, 0));
                sched.push_back(mk(0, 0, 1, 1, 1));
                sched.push_back(mk(0, 0, 0, 0, 0));
            end
`ifdef TRAP_MRET_EN
            else if (bus.mret) begin
                sched.push_back(mk(0, 1, 0, 1, 2));
                sched.push_back(mk(0, 0, 0, 0, 0));
            end
`endif
        end
        if (sched.size() > 0) cur = sched.pop_front();
        else                  cur = mk(0, 0, 0, 0, 0);
    endtask

    task automatic check_all(string tag);
        logic [31:0] exp_rpc;
        exp_rpc = (cur.sel == 1) ? bus.csr_mtvec : (cur.sel == 2) ? bus.csr_mepc : 32'h0;
        chk({tag, ".exception"},      32'(bus.exception),      32'(cur.exc));
        chk({tag, ".flush"},          32'(bus.flush),          32'(cur.flush));
        chk({tag, ".stall"},          32'(bus.stall),          32'(cur.stall));
        chk({tag, ".redirect_valid"}, 32'(bus.redirect_valid), 32'(cur.rv));
        chk({tag, ".redirect_pc"},    bus.redirect_pc,         exp_rpc);
        chk({tag, ".exception_code"}, 32'(bus.exception_code), 32'(m_code));
        chk({tag, ".trap_pc"},        bus.trap_pc,             m_pc);
        chk({tag, ".trap_instr"},     bus.trap_instr,          m_instr);
    endtask

    task automatic cycle(string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached before test end");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [4:0] hist;
        drive(0, 6'b0, 0, 32'h0, 32'h0);
        bus.csr_mtvec = 32'h400;
        bus.csr_mepc  = 32'h104;
        m_code = '0; m_pc = '0; m_instr = '0;
        cur = mk(0, 0, 0, 0, 0);

        // Reset state
        cycle("reset");
        cycle("reset");
        reset = 1'b1;
        cycle("post_reset");

        // Directed vector table
        vecs.push_back(mkv(1, F_ILL,           0, 32'h100, 32'hFFFF_FFFF, 1, 8'h02));
        vecs.push_back(mkv(1, F_ECALL|F_LOAD,  0, 32'h108, 32'h0000_0073, 1, 8'h0B));
        vecs.push_back(mkv(1, 6'b111111,       0, 32'h10C, 32'h1234_5678, 1, 8'h00));
        vecs.push_back(mkv(1, F_STORE,         0, 32'h110, 32'hAAAA_5555, 1, 8'h06));
        vecs.push_back(mkv(1, F_LOAD|F_STORE,  0, 32'h114, 32'h0BAD_F00D, 1, 8'h04));
        vecs.push_back(mkv(1, F_EBRK|F_ECALL,  0, 32'h118, 32'h0010_0073, 1, 8'h03));
        vecs.push_back(mkv(1, F_ILL|F_STORE,   0, 32'h11C, 32'hDEAD_BEEF, 1, 8'h02));
        vecs.push_back(mkv(1, F_FETCH,         0, 32'h122, 32'h0000_0013, 1, 8'h00));
        vecs.push_back(mkv(1, 6'b0,            0, 32'h120, 32'h0000_0001, 0, 8'h00));
        vecs.push_back(mkv(0, F_ILL,           0, 32'h124, 32'h0000_0002, 0, 8'h00));
`ifdef TRAP_MRET_EN
        vecs.push_back(mkv(0, 6'b0,            1, 32'h200, 32'h3020_0073, 0, 8'h00));
`else
        vecs.push_back(mkv(0, 6'b0,            1, 32'h200, 32'h3020_0073, 1, 8'h02));
`endif
        foreach (vecs[k]) begin
            drive(vecs[k].valid, vecs[k].flags, vecs[k].mret, vecs[k].pc, vecs[k].instr);
            cycle($sformatf("vec%0d", k));
            chk($sformatf("vec%0d.pulse", k), 32'(bus.exception), 32'(vecs[k].exp_exc));
            if (vecs[k].exp_exc) begin
                chk($sformatf("vec%0d.code", k),  32'(bus.exception_code), 32'(vecs[k].exp_code));
                chk($sformatf("vec%0d.pc", k),    bus.trap_pc,    vecs[k].pc);
                chk($sformatf("vec%0d.instr", k), bus.trap_instr, vecs[k].instr);
                chk($sformatf("vec%0d.stall1", k), 32'(bus.stall), 32'd1);
            end
`ifdef TRAP_MRET_EN
            else if (vecs[k].mret) begin
                chk($sformatf("vec%0d.mret_rv", k),  32'(bus.redirect_valid), 32'd1);
                chk($sformatf("vec%0d.mret_pc", k),  bus.redirect_pc, 32'h104);
                chk($sformatf("vec%0d.mret_fl", k),  32'(bus.flush), 32'd1);
            end
`endif
            drive(0, 6'b0, 0, 32'h0, 32'h0);
            cycle($sformatf("vec%0d.c2", k));
            if (vecs[k].exp_exc) chk($sformatf("vec%0d.stall2", k), 32'(bus.stall), 32'd1);
            cycle($sformatf("vec%0d.c3", k));
            if (vecs[k].exp_exc) begin
                chk($sformatf("vec%0d.rv3", k),  32'(bus.redirect_valid), 32'd1);
                chk($sformatf("vec%0d.rpc3", k), bus.redirect_pc, 32'h400);
            end
            cycle($sformatf("vec%0d.c4", k));
            chk($sformatf("vec%0d.stall4", k), 32'(bus.stall), 32'd0);
        end

        // Reset asserted in the middle of REDIRECT
        drive(1, F_ILL, 0, 32'h300, 32'h0000_FFFF);
        cycle("rst_mid.save");
        drive(0, 6'b0, 0, 32'h0, 32'h0);
        cycle("rst_mid.wait");
        cycle("rst_mid.redirect");
        chk("rst_mid.rv_before", 32'(bus.redirect_valid), 32'd1);
        #2 reset = 1'b0;
        #1;
        chk("rst_mid.async_rv",   32'(bus.redirect_valid), 32'd0);
        chk("rst_mid.async_rpc",  bus.redirect_pc, 32'h0);
        chk("rst_mid.async_code", 32'(bus.exception_code), 32'd0);
        chk("rst_mid.async_pc",   bus.trap_pc, 32'h0);
        cycle("rst_mid.held");
        reset = 1'b1;
        drive(1, F_ECALL, 0, 32'h304, 32'h0000_0073);
        cycle("rst_mid.new_req");
        chk("rst_mid.new_exc",  32'(bus.exception), 32'd1);
        chk("rst_mid.new_code", 32'(bus.exception_code), 32'h0B);
        drive(0, 6'b0, 0, 32'h0, 32'h0);
        repeat (3) cycle("rst_mid.drain");

        // Back-to-back ecall at N and N+4, ignored ebreak at N+2
        hist = '0;
        drive(1, F_ECALL, 0, 32'h500, 32'h0000_0073);
        cycle("b2b.n1");  hist[0] = bus.exception;
        drive(0, 6'b0, 0, 32'h0, 32'h0);
        cycle("b2b.n2");  hist[1] = bus.exception;
        drive(1, F_EBRK, 0, 32'h600, 32'h0010_0073);
        cycle("b2b.n3");  hist[2] = bus.exception;
        drive(0, 6'b0, 0, 32'h0, 32'h0);
        cycle("b2b.n4");  hist[3] = bus.exception;
        drive(1, F_ECALL, 0, 32'h700, 32'h0000_0073);
        cycle("b2b.n5");  hist[4] = bus.exception;
        chk("b2b.pulse_pattern", 32'(hist), 32'b10001);
        chk("b2b.second_pc",     bus.trap_pc, 32'h700);
        chk("b2b.second_code",   32'(bus.exception_code), 32'h0B);
        drive(0, 6'b0, 0, 32'h0, 32'h0);
        repeat (3) cycle("b2b.drain");

        // Simultaneous exception and mret: trap wins
        drive(1, F_ECALL, 1, 32'h800, 32'h0000_0073);
        cycle("sim.save");
        chk("sim.exc", 32'(bus.exception), 32'd1);
        chk("sim.no_mret_rv", 32'(bus.redirect_valid), 32'd0);
        drive(0, 6'b0, 0, 32'h0, 32'h0);
        cycle("sim.wait");
        cycle("sim.redirect");
        chk("sim.rpc", bus.redirect_pc, 32'h400);
        cycle("sim.idle");

        // Randomized traffic
        for (int n = 0; n < 500; n++) begin
            reset = ($urandom_range(0, 59) != 0);
            drive(1'($urandom_range(0, 1)),
                  {1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0),
                   1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0),
                   1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 5) == 0)},
                  1'($urandom_range(0, 5) == 0), $urandom(), $urandom());
            bus.csr_mtvec = $urandom() & 32'hFFFF_FFFC;
            bus.csr_mepc  = $urandom();
            cycle("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/trap_controller.md
# trap_controller

Trap sequencer that drives the machine-mode CSR file's exception interface and redirects the pipeline. It sits between the execute/decode stage and the CSR block. It collects synchronous exception requests and prioritises them into one `exception_code`. It pulses `exception` with the faulting `pc`/`instr` so the CSR file latches `mepc`/`mcause`/`mtval`, then redirects fetch to `csr_mtvec`. It also handles `mret` by redirecting to `csr_mepc`.

## Interface
- `DATA_WIDTH`, 32, width of PC, instruction and CSR values (matches `` `DATA_WIDTH `` in `sabit_veriler.vh`)
- `clk`  in  1  single clock, rising edge
- `reset`  in  1  asynchronous, active-low reset
- `exc_valid`  in  1  exception request from pipeline for the instruction at `exc_pc`
- `exc_fetch_misaligned`, `exc_illegal`, `exc_ebreak`, `exc_ecall`, `exc_load_misaligned`, `exc_store_misaligned`  in  1 each  cause flags, qualified by `exc_valid`
- `exc_pc`  in  DATA_WIDTH  PC of the faulting instruction
- `exc_instr`  in  DATA_WIDTH  faulting instruction word
- `mret`  in  1  MRET retiring this cycle
- `csr_mtvec`  in  DATA_WIDTH  trap vector from CSR file (already 4-byte aligned)
- `csr_mepc`  in  DATA_WIDTH  saved PC from CSR file
- `exception`  out  1  to CSR file; one-cycle pulse per trap
- `exception_code`  out  8  to CSR file; cause code
- `trap_pc`  out  DATA_WIDTH  to CSR `pc`
- `trap_instr`  out  DATA_WIDTH  to CSR `instr`
- `flush`  out  1  kill younger pipeline instructions
- `stall`  out  1  hold pipeline while sequencing
- `redirect_valid`  out  1  load fetch PC with `redirect_pc`
- `redirect_pc`  out  DATA_WIDTH  new fetch PC

## Operation
- States: IDLE, SAVE, WAIT, REDIRECT, MRET.
- IDLE: if `exc_valid` has at least one flag set, latch code, `exc_pc` and `exc_instr`, then go to SAVE. Otherwise, if `mret`, go to MRET. `exc_valid` with no flag set is ignored.
- Priority, highest first (code): fetch misaligned (0x00), illegal (0x02), ebreak (0x03), ecall (0x0B), load misaligned (0x04), store misaligned (0x06).
- SAVE: `exception`=1, `flush`=1, `stall`=1. Go to WAIT.
- WAIT: `exception`=0, `stall`=1. Lets the CSR update land. Go to REDIRECT.
- REDIRECT: `redirect_valid`=1, `redirect_pc`=`csr_mtvec`, `stall`=1. Go to IDLE.
- MRET: `redirect_valid`=1, `redirect_pc`=`csr_mepc`, `flush`=1. Go to IDLE.
- `exception` is never high in two consecutive cycles. Every trap is therefore a distinct rising edge for the CSR edge detector.
- `exception_code`, `trap_pc` and `trap_instr` are registered and hold the last trap's values until the next trap.
- Simultaneous `exc_valid` and `mret` in IDLE: the exception wins and `mret` is dropped.
- Requests arriving outside IDLE are ignored. The pipeline is stalled/flushed, so they do not retire.
- Reset low: state goes to IDLE immediately. All outputs become 0, including `exception_code`, `trap_pc` and `trap_instr`. Reset during any state aborts the sequence with no redirect.

## Timing
- Trap, with request sampled at edge N: `exception`/`flush` high in cycle N+1. WAIT in N+2. `redirect_valid` in N+3. IDLE in N+4, where a new request is accepted.
- Trap latency from request to redirect is 3 cycles. `stall` is high for 3 cycles.
- MRET, sampled at edge N: `redirect_valid`/`flush` high in cycle N+1 only. Back in IDLE at N+2.
- `redirect_pc` is combinational from `csr_mtvec`/`csr_mepc` in the REDIRECT/MRET states and 0 otherwise.

## Configuration
- `TRAP_MRET_EN` defined: MRET state and `mret` handling present, as above.
- `TRAP_MRET_EN` undefined: no MRET state. An `mret` in IDLE is treated as an illegal instruction: code 0x02, `trap_pc`=`exc_pc`, `trap_instr`=`exc_instr`, full trap sequence.

## Test plan
- Reset low mid-REDIRECT: next cycle all outputs are 0 and no `redirect_valid` is seen. After release, a new request is accepted.
- `exc_valid`+`exc_illegal`, `exc_pc`=0x100, `exc_instr`=0xFFFFFFFF, `csr_mtvec`=0x400: `exception` pulses at N+1 with code 0x02, `trap_pc`=0x100, `trap_instr`=0xFFFFFFFF. `redirect_valid` at N+3 with `redirect_pc`=0x400. `stall` high N+1..N+3.
- `exc_ecall` and `exc_load_misaligned` together: code 0x0B. `exc_fetch_misaligned` plus all others: code 0x00.
- `mret` with `csr_mepc`=0x104 (MRET_EN): `redirect_valid` and `flush` for one cycle at N+1, `redirect_pc`=0x104, `exception` stays 0. Without MRET_EN: trap with code 0x02.
- Back-to-back ecall at N and N+4: two separate one-cycle `exception` pulses with `exception` low between them. A request at N+2 is ignored.
- `exc_valid` and `mret` in the same cycle: trap sequence only, no MRET redirect to `csr_mepc`.
